sfpp_link_sequencer: RTL

Autonomous bring-up and recovery controller for the SFP+ 10G transceiver/PHY.
- Drives the six transceiver control bits.
- Watches the synchronized transceiver and PHY status: power good, PLL locks, reset-done and userclk-active flags, block lock, high BER.
- Sequences reset release, retries with back-off on timeout, and performs RX-datapath recovery on link loss.
- Sits in the wishbone/system clock domain, beside the SFP+ wishbone register block. The register block muxes this block's control output against its software control register.

---
 rtl/sfpp_link_pkg.sv | 43 ++++
 rtl/sfpp_link_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sfpp_link_pkg.sv
// Shared definitions for the SFP+ link sequencer and the wishbone register block
// that muxes the sequencer's transceiver control against software control.
package sfpp_link_pkg;

  typedef enum logic [3:0] {
    ST_DISABLED   = 4'd0,
    ST_HOLD_RESET = 4'd1,
    ST_WAIT_PLL   = 4'd2,
    ST_WAIT_TX    = 4'd3,
    ST_WAIT_RX    = 4'd4,
    ST_WAIT_LOCK  = 4'd5,
    ST_LINK_UP    = 4'd6,
    ST_RX_RECOVER = 4'd7,
    ST_BACKOFF    = 4'd8,
    ST_FAILED     = 4'd9
  } seq_state_e;

  localparam int CTRL_W         = 6;
  localparam int STS_W          = 13;
  localparam int CTRL_FULL_RST  = 0;
  localparam int CTRL_RX_DP_RST = 3;

  localparam int STS_POWERGOOD  = 0;
  localparam int STS_TX_DONE    = 4;
  localparam int STS_RX_DONE    = 7;
  localparam int STS_TX_USRCLK  = 8;
  localparam int STS_RX_USRCLK  = 9;
  localparam int STS_EXT_PLL    = 10;
  localparam int STS_QPLL       = 11;

  // Control word the transceiver sees while the sequencer sits in a given state.
  function automatic logic [CTRL_W-1:0] ctrl_for_state(input seq_state_e s);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (s)
      ST_DISABLED, ST_HOLD_RESET, ST_BACKOFF, ST_FAILED: c[CTRL_FULL_RST] = 1'b1;
      ST_RX_RECOVER:                                    c[CTRL_RX_DP_RST] = 1'b1;
      default:                                          c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sfpp_link_sequencer.sv
// Bring-up / recovery sequencer for the SFP+ 10G transceiver and PHY: releases
// resets in order, waits for locks, retries with back-off and recovers the RX path.
module sfpp_link_sequencer
  import sfpp_link_pkg::*;
#(
  parameter int unsigned RESET_CYCLES       = 1024,
  parameter int unsigned TIMEOUT_CYCLES     = 1048576,
  parameter int unsigned LOCK_STABLE_CYCLES = 65536,
  parameter int unsigned DROP_FILTER_CYCLES = 256,
  parameter int unsigned BACKOFF_CYCLES     = 262144,
  parameter int unsigned MAX_RETRIES        = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [STS_W-1:0]  transceiver_status,
  input  logic              phy_block_lock,
  input  logic              phy_high_ber,
  output logic [CTRL_W-1:0] transceiver_control,
  output logic              link_up,
  output logic              failed,
  output logic [3:0]        state,
  output logic [7:0]        retry_count,
  output logic [15:0]       link_drop_count
);

  localparam int unsigned MAX_A = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_B = (LOCK_STABLE_CYCLES > DROP_FILTER_CYCLES) ? LOCK_STABLE_CYCLES : DROP_FILTER_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > BACKOFF_CYCLES) ? MAX_C : BACKOFF_CYCLES;
  localparam int TW = $clog2(MAX_CYC) + 1;

  seq_state_e        r_state, w_next, w_wait_dest, w_to_state;
  logic [TW-1:0]     r_timer, r_stab, r_drop_filt;
  logic [7:0]        r_retry, w_retry_next, w_retry_inc;
  logic [15:0]       r_drops, w_drops_next;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_link_up, r_failed;
  logic              w_good, w_tx_ok, w_rx_ok, w_pll_ok, w_wait_ok, w_timeout;
  logic              w_unused_status;

  assign w_good    = phy_block_lock & ~phy_high_ber;
  assign w_pll_ok  = transceiver_status[STS_POWERGOOD] & transceiver_status[STS_EXT_PLL] &
                     transceiver_status[STS_QPLL];
  assign w_tx_ok   = transceiver_status[STS_TX_DONE] & transceiver_status[STS_TX_USRCLK];
  assign w_rx_ok   = transceiver_status[STS_RX_DONE] & transceiver_status[STS_RX_USRCLK];
  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_unused_status = ^{transceiver_status[12], transceiver_status[6:5], transceiver_status[3:1]};

  assign w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
  assign w_to_state  = (w_retry_inc >= 8'(MAX_RETRIES)) ? ST_FAILED : ST_BACKOFF;

  // Exit condition and destination of whichever WAIT_* state is current.
  always_comb begin
    w_wait_ok   = 1'b0;
    w_wait_dest = ST_WAIT_TX;
    case (r_state)
      ST_WAIT_PLL:  begin w_wait_ok = w_pll_ok; w_wait_dest = ST_WAIT_TX;   end
      ST_WAIT_TX:   begin w_wait_ok = w_tx_ok;  w_wait_dest = ST_WAIT_RX;   end
      ST_WAIT_RX:   begin w_wait_ok = w_rx_ok;  w_wait_dest = ST_WAIT_LOCK; end
      ST_WAIT_LOCK: begin
        w_wait_ok   = w_good && (r_stab == TW'(LOCK_STABLE_CYCLES - 1));
        w_wait_dest = ST_LINK_UP;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_drops_next = r_drops;
    if (!enable) begin
      w_next       = ST_DISABLED;
      w_retry_next = 8'd0;
      w_drops_next = 16'd0;
    end else begin
      case (r_state)
        ST_DISABLED:   w_next = ST_HOLD_RESET;
        ST_HOLD_RESET: if (r_timer == TW'(RESET_CYCLES - 1)) w_next = ST_WAIT_PLL;
        ST_WAIT_PLL, ST_WAIT_TX, ST_WAIT_RX, ST_WAIT_LOCK: begin
          // A condition met on the expiry cycle still counts as success.
          if (w_wait_ok) begin
            w_next = w_wait_dest;
          end else if (w_timeout) begin
            w_next       = w_to_state;
            w_retry_next = w_retry_inc;
          end
        end
        ST_LINK_UP: begin
          if (!(transceiver_status[STS_TX_DONE] && transceiver_status[STS_RX_DONE])) begin
            w_next = ST_BACKOFF;
          end else if (!w_good && (r_drop_filt == TW'(DROP_FILTER_CYCLES - 1))) begin
            w_next       = ST_RX_RECOVER;
            w_drops_next = (r_drops == 16'hFFFF) ? r_drops : r_drops + 16'd1;
          end
        end
        ST_RX_RECOVER: if (r_timer == TW'(RESET_CYCLES - 1)) w_next = ST_WAIT_RX;
        ST_BACKOFF:    if (r_timer == TW'(BACKOFF_CYCLES - 1)) w_next = ST_HOLD_RESET;
        ST_FAILED:     w_next = ST_FAILED;
        default:       w_next = ST_DISABLED;
      endcase
      if ((w_next == ST_LINK_UP) && (r_state != ST_LINK_UP)) w_retry_next = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_DISABLED;
      r_timer     <= '0;
      r_stab      <= '0;
      r_drop_filt <= '0;
      r_retry     <= 8'd0;
      r_drops     <= 16'd0;
      r_ctrl      <= 6'b000001;
      r_link_up   <= 1'b0;
      r_failed    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_timer     <= (w_next != r_state) ? '0 : r_timer + 1'b1;
      r_stab      <= ((w_next == r_state) && (r_state == ST_WAIT_LOCK) && w_good) ?
                     r_stab + 1'b1 : '0;
      r_drop_filt <= ((w_next == r_state) && (r_state == ST_LINK_UP) && !w_good) ?
                     r_drop_filt + 1'b1 : '0;
      r_retry     <= w_retry_next;
      r_drops     <= w_drops_next;
      r_ctrl      <= ctrl_for_state(w_next);
      r_link_up   <= (w_next == ST_LINK_UP);
      r_failed    <= (w_next == ST_FAILED);
    end
  end

  assign transceiver_control = r_ctrl;
  assign link_up             = r_link_up;
  assign failed              = r_failed;
  assign state               = r_state;
  assign retry_count         = r_retry;
  assign link_drop_count     = r_drops;

endmodule
